// File: rtl/store_commit_buffer_pkg.sv
// rtl/store_commit_buffer_pkg.sv - shared constants, state type and size helper for the store commit buffer
package store_commit_buffer_pkg;

  localparam logic [2:0] REQUIRE8  = 3'd1;
  localparam logic [2:0] REQUIRE16 = 3'd2;
  localparam logic [2:0] REQUIRE32 = 3'd4;

  // Stores whose addr[17:16] match this region target the UART and may stall.
  localparam logic [1:0] IO_REGION = 2'b11;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } scb_state_t;

  function automatic logic is_legal_size(input logic [2:0] size);
    return (size == REQUIRE8) || (size == REQUIRE16) || (size == REQUIRE32);
  endfunction

endpackage

// File: rtl/scb_fifo.sv
// rtl/scb_fifo.sv - committed-store FIFO: storage, head/tail pointers, count and per-slot valid bits
module scb_fifo
  import store_commit_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 67
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [WIDTH-1:0]       o_head,
  output logic [DEPTH-1:0]       o_valid,
  output logic [DEPTH*WIDTH-1:0] o_entries
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  logic [DEPTH-1:0] r_valid;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == DEPTH_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_head];
  assign o_valid   = r_valid;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push_ok) begin
        r_tail          <= r_tail + 1'b1;
        r_valid[r_tail] <= TRUE;
      end
      if (w_pop_ok) begin
        r_head          <= r_head + 1'b1;
        r_valid[r_head] <= FALSE;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign o_entries[g*WIDTH +: WIDTH] = r_mem[g];
  end

endmodule

// File: rtl/store_commit_buffer.sv
// rtl/store_commit_buffer.sv - drains committed stores to the byte-wide memory port in commit order
// Optional STORE_QUERY_EN adds a word-granular load/store alias compare on query_addr.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rdy,
  input  logic              i_commit_en,
  input  logic [2:0]        i_commit_size,
  input  logic [ADDR_W-1:0] i_commit_addr,
  input  logic [DATA_W-1:0] i_commit_value,
  output logic              o_buf_full,
  output logic              o_buf_empty,
  output logic              o_store_pending,
  output logic              o_mem_req,
  input  logic              i_mem_grant,
  output logic [ADDR_W-1:0] o_mem_a,
  output logic [7:0]        o_mem_dout,
  output logic              o_mem_wr,
  input  logic              i_io_buffer_full,
  input  logic [ADDR_W-1:0] i_query_addr,
  output logic              o_query_conflict
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + ADDR_W + DATA_W;
  localparam logic [AW:0] FULL_THR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  scb_state_t        r_state;
  scb_state_t        w_next_state;
  logic [2:0]        r_k;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;

  logic              w_push;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [AW:0]       w_count;
  logic [EW-1:0]     w_head;
  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH*EW-1:0] w_entries;
  logic [2:0]        w_head_size;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_value;
  logic [ADDR_W-1:0] w_byte_addr;
  logic [7:0]        w_byte;
  logic              w_io_stall;
  logic              w_issue;
  logic              w_last;
  logic              w_pop;
  logic              w_more;
  logic              w_unused_q;

  assign w_push = i_commit_en && i_rdy;

  scb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data ({i_commit_size, i_commit_addr, i_commit_value}),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_count),
    .o_head      (w_head),
    .o_valid     (w_valid),
    .o_entries   (w_entries)
  );

  assign w_head_size  = w_head[EW-1 -: 3];
  assign w_head_addr  = w_head[DATA_W +: ADDR_W];
  assign w_head_value = w_head[DATA_W-1:0];
  assign w_byte_addr  = w_head_addr + ADDR_W'(r_k);

  always_comb begin
    w_byte = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (r_k == 3'(b)) begin
        w_byte = w_head_value[8*b +: 8];
      end
    end
  end

  // UART back-pressure only applies to stores aimed at the IO region.
  assign w_io_stall = (w_head_addr[17:16] == IO_REGION) && i_io_buffer_full;
  assign w_issue    = (r_state == S_WRITE) && i_mem_grant && i_rdy && !w_io_stall;
  assign w_last     = (r_k == (w_head_size - 3'd1));
  assign w_pop      = w_issue && w_last;
  assign w_more     = (w_count > CNT_ONE) || w_push;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else if (i_rdy) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_fifo_empty) w_next_state = S_WRITE;
      S_WRITE: if (w_pop && !w_more) w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req = FALSE;
    if (r_state == S_WRITE) begin
      o_mem_req = TRUE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_k        <= '0;
      r_mem_wr   <= FALSE;
      r_mem_a    <= '0;
      r_mem_dout <= '0;
    end else if (i_rdy) begin
      r_mem_wr <= w_issue;
      if (w_issue) begin
        r_mem_a    <= w_byte_addr;
        r_mem_dout <= w_byte;
      end
      if ((r_state == S_IDLE) || w_pop) begin
        r_k <= '0;
      end else if (w_issue) begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  always @(posedge i_clk) begin
    if (!i_rst && w_push) begin
      assert (!w_fifo_full);
      assert (is_legal_size(i_commit_size));
    end
  end

  // The write strobe is suppressed while the core is frozen so a held strobe is not seen twice.
  assign o_mem_wr        = r_mem_wr && i_rdy;
  assign o_mem_a         = r_mem_a;
  assign o_mem_dout      = r_mem_dout;
  assign o_buf_full      = (w_count >= FULL_THR);
  assign o_buf_empty     = w_fifo_empty && (r_state == S_IDLE);
  assign o_store_pending = !o_buf_empty;

`ifdef STORE_QUERY_EN
  logic w_hit;

  always_comb begin
    w_hit = FALSE;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] &&
          (w_entries[i*EW + DATA_W + 2 +: ADDR_W-2] == i_query_addr[ADDR_W-1:2])) begin
        w_hit = TRUE;
      end
    end
  end

  assign o_query_conflict = w_hit;
  assign w_unused_q       = ^{i_query_addr[1:0], w_entries};
`else
  assign o_query_conflict = o_store_pending;
  assign w_unused_q       = ^{i_query_addr, w_entries, w_valid};
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// tb/tb_store_commit_buffer.sv - directed vector table plus corner-case sequences for store_commit_buffer
module tb_store_commit_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        commit_en;
  logic [2:0]  commit_size;
  logic [31:0] commit_addr;
  logic [31:0] commit_value;
  logic        buf_full;
  logic        buf_empty;
  logic        store_pending;
  logic        mem_req;
  logic        mem_grant;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_full;
  logic [31:0] query_addr;
  logic        query_conflict;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  store_commit_buffer #(.DEPTH(8), .ADDR_W(32), .DATA_W(32)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rdy            (rdy),
    .i_commit_en      (commit_en),
    .i_commit_size    (commit_size),
    .i_commit_addr    (commit_addr),
    .i_commit_value   (commit_value),
    .o_buf_full       (buf_full),
    .o_buf_empty      (buf_empty),
    .o_store_pending  (store_pending),
    .o_mem_req        (mem_req),
    .i_mem_grant      (mem_grant),
    .o_mem_a          (mem_a),
    .o_mem_dout       (mem_dout),
    .o_mem_wr         (mem_wr),
    .i_io_buffer_full (io_full),
    .i_query_addr     (query_addr),
    .o_query_conflict (query_conflict)
  );

  // in = {commit_en, grant, io_full, rdy}; out = {wr, req, empty, full, check_a_and_dout}
  typedef struct {
    logic [3:0]  in;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] value;
    logic [4:0]  out;
    logic [31:0] a;
    logic [7:0]  d;
  } vec_t;

  vec_t v[$];

  task automatic add(input logic [3:0] in, input logic [2:0] sz, input logic [31:0] ad,
                     input logic [31:0] val, input logic [4:0] out, input logic [31:0] a,
                     input logic [7:0] d);
    vec_t t;
    t.in = in; t.size = sz; t.addr = ad; t.value = val; t.out = out; t.a = a; t.d = d;
    v.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, "_mem_a"}, mem_a, 32'h0);
    chk({tag, "_mem_dout"}, 32'(mem_dout), 32'h0);
    chk({tag, "_buf_full"}, 32'(buf_full), 32'h0);
    chk({tag, "_buf_empty"}, 32'(buf_empty), 32'h1);
    chk({tag, "_store_pending"}, 32'(store_pending), 32'h0);
    chk({tag, "_query_conflict"}, 32'(query_conflict), 32'h0);
  endtask

  initial begin
    int nwr;
    logic [7:0] e_d;
    logic [31:0] e_a;

    rst = 1'b1; rdy = 1'b1; commit_en = 1'b0; commit_size = 3'd1; commit_addr = '0;
    commit_value = '0; mem_grant = 1'b0; io_full = 1'b0; query_addr = 32'hFFF0_0000;
    step();
    step();
    check_reset_values("reset");
    rst = 1'b0;

    // SW 0xDEADBEEF at 0x100 drains LSB first on four consecutive cycles
    add(4'b1101, 3'd4, 32'h100, 32'hDEADBEEF, 5'b00000, 32'h0, 8'h0);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b01000, 32'h0, 8'h0);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b11001, 32'h100, 8'hEF);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b11001, 32'h101, 8'hBE);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b11001, 32'h102, 8'hAD);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b10101, 32'h103, 8'hDE);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b00101, 32'h103, 8'hDE);
    // SB to the IO region stalls three cycles on io_buffer_full
    add(4'b1101, 3'd1, 32'h30000, 32'h41, 5'b00001, 32'h103, 8'hDE);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b01000, 32'h0, 8'h0);
    add(4'b0111, 3'd1, 32'h0, 32'h0, 5'b01001, 32'h103, 8'hDE);
    add(4'b0111, 3'd1, 32'h0, 32'h0, 5'b01001, 32'h103, 8'hDE);
    add(4'b0111, 3'd1, 32'h0, 32'h0, 5'b01001, 32'h103, 8'hDE);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b10101, 32'h30000, 8'h41);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b00100, 32'h0, 8'h0);
    // outside the IO region io_buffer_full is ignored
    add(4'b1111, 3'd1, 32'h20000, 32'h07, 5'b00000, 32'h0, 8'h0);
    add(4'b0111, 3'd1, 32'h0, 32'h0, 5'b01000, 32'h0, 8'h0);
    add(4'b0111, 3'd1, 32'h0, 32'h0, 5'b10101, 32'h20000, 8'h07);
    // SH crossing the top of the address space wraps to 0
    add(4'b1101, 3'd2, 32'hFFFFFFFF, 32'hBBAA, 5'b00000, 32'h0, 8'h0);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b01000, 32'h0, 8'h0);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b11001, 32'hFFFFFFFF, 8'hAA);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b10101, 32'h0, 8'hBB);
    // rdy low freezes state and masks the write strobe
    add(4'b1101, 3'd2, 32'h200, 32'h1122, 5'b00000, 32'h0, 8'h0);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b01000, 32'h0, 8'h0);
    add(4'b0100, 3'd1, 32'h0, 32'h0, 5'b01001, 32'h0, 8'hBB);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b11001, 32'h200, 8'h22);
    add(4'b0100, 3'd1, 32'h0, 32'h0, 5'b01001, 32'h200, 8'h22);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b10101, 32'h201, 8'h11);
    // commit lands on the final byte of the head: next store follows with k=0
    add(4'b1101, 3'd1, 32'h300, 32'h5A, 5'b00000, 32'h0, 8'h0);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b01000, 32'h0, 8'h0);
    add(4'b1101, 3'd1, 32'h400, 32'hA5, 5'b11001, 32'h300, 8'h5A);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b10101, 32'h400, 8'hA5);
    add(4'b0101, 3'd1, 32'h0, 32'h0, 5'b00100, 32'h0, 8'h0);

    foreach (v[i]) begin
      commit_en = v[i].in[3]; mem_grant = v[i].in[2]; io_full = v[i].in[1]; rdy = v[i].in[0];
      commit_size = v[i].size; commit_addr = v[i].addr; commit_value = v[i].value;
      step();
      chk($sformatf("v%0d_wr", i), 32'(mem_wr), 32'(v[i].out[4]));
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(v[i].out[3]));
      chk($sformatf("v%0d_empty", i), 32'(buf_empty), 32'(v[i].out[2]));
      chk($sformatf("v%0d_full", i), 32'(buf_full), 32'(v[i].out[1]));
      chk($sformatf("v%0d_pending", i), 32'(store_pending), 32'(!v[i].out[2]));
`ifndef STORE_QUERY_EN
      chk($sformatf("v%0d_qconf", i), 32'(query_conflict), 32'(!v[i].out[2]));
`endif
      if (v[i].out[0]) begin
        chk($sformatf("v%0d_a", i), mem_a, v[i].a);
        chk($sformatf("v%0d_dout", i), 32'(mem_dout), 32'(v[i].d));
      end
    end
    rdy = 1'b1; io_full = 1'b0; commit_en = 1'b0;

    // seven SH with no grant fill to the threshold, then drain across the pointer wrap
    mem_grant = 1'b0;
    for (int i = 0; i < 7; i++) begin
      commit_en = 1'b1; commit_size = 3'd2;
      commit_addr = 32'h1000 + 32'(16 * i);
      commit_value = {16'h0, 8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i)};
      step();
      chk($sformatf("fill%0d_full", i), 32'(buf_full), 32'(i == 6));
    end
    commit_en = 1'b0;
    mem_grant = 1'b1;
    nwr = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (mem_wr) begin
        e_a = 32'h1000 + 32'(16 * (nwr / 2)) + 32'(nwr % 2);
        e_d = 8'(8'h10 + 2 * (nwr / 2) + (nwr % 2));
        chk($sformatf("drain%0d_a", nwr), mem_a, e_a);
        chk($sformatf("drain%0d_dout", nwr), 32'(mem_dout), 32'(e_d));
        nwr++;
      end
    end
    chk("drain_bytes", 32'(nwr), 32'd14);
    chk("drain_empty", 32'(buf_empty), 32'h1);
    chk("drain_full", 32'(buf_full), 32'h0);

    // reset after two bytes of a SW abandons the rest
    commit_en = 1'b1; commit_size = 3'd4; commit_addr = 32'h500; commit_value = 32'h44332211;
    step();
    commit_en = 1'b0;
    step();
    step();
    chk("rst_b0_wr", 32'(mem_wr), 32'h1);
    chk("rst_b0_dout", 32'(mem_dout), 32'h11);
    step();
    chk("rst_b1_a", mem_a, 32'h501);
    chk("rst_b1_dout", 32'(mem_dout), 32'h22);
    rst = 1'b1;
    step();
    check_reset_values("midrst");
    rst = 1'b0;
    nwr = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (mem_wr) nwr++;
    end
    chk("midrst_no_wr", 32'(nwr), 32'h0);
    chk("midrst_empty", 32'(buf_empty), 32'h1);

`ifdef STORE_QUERY_EN
    mem_grant = 1'b0;
    commit_en = 1'b1; commit_size = 3'd4; commit_addr = 32'h204; commit_value = 32'h1;
    step();
    commit_en = 1'b0;
    query_addr = 32'h206;
    #1;
    chk("query_same_word", 32'(query_conflict), 32'h1);
    query_addr = 32'h208;
    #1;
    chk("query_next_word", 32'(query_conflict), 32'h0);
    mem_grant = 1'b1;
    for (int c = 0; c < 8; c++) step();
    query_addr = 32'h206;
    #1;
    chk("query_after_drain", 32'(query_conflict), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
